// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : RV32I fetch stage plus IF/ID pipeline register. Holds the fetch
//            PC, issues single-outstanding instruction-memory requests, absorbs
//            memory wait states, decode stalls (via a one-entry skid buffer)
//            and execute-stage redirects (via an abort/drop state).
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    // REQ : request outstanding at PCF
    // DROP: an aborted request is still in flight; its response is discarded
    // BUF : a response arrived during a decode stall and sits in the skid buffer
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_DROP = 2'd1,
        S_BUF  = 2'd2
    } state_t;

    localparam logic [31:0] C_PC_STEP       = 32'd4;
    localparam logic [31:0] C_RESET_PC_WORD = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    // Source feeding the IF/ID register this cycle (response or skid buffer)
    logic        w_src_valid;
    logic [31:0] w_src_instr;
    logic [31:0] w_src_pc;

    logic [31:0] w_target;
    logic [31:0] w_pcf_plus4;
    logic [31:0] w_src_pc_plus4;
    logic        w_unused_target_lsbs;

    // Redirect targets are forced to word alignment; the low bits carry nothing
    assign w_target             = {PCTargetE[31:2], 2'b00};
    assign w_unused_target_lsbs = ^PCTargetE[1:0];
    assign w_pcf_plus4          = pcf_q + C_PC_STEP;
    assign w_src_pc_plus4       = w_src_pc + C_PC_STEP;

    // Request interface is purely registered: the address cannot move while waiting
    assign ImemReq  = (state_q != S_BUF);
    assign ImemAddr = (state_q == S_DROP) ? drop_addr_q : pcf_q;

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

    // Fetch FSM: next state, next PC, skid buffer and IF/ID source selection
    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        drop_addr_d = drop_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        w_src_valid = 1'b0;
        w_src_instr = ImemRData;
        w_src_pc    = pcf_q;

        unique case (state_q)
            S_REQ: begin
                if (PCSrcE) begin
                    pcf_d = w_target;
                    if (!ImemReady) begin
                        // Request already on the bus: remember it and wait it out
                        state_d     = S_DROP;
                        drop_addr_d = pcf_q;
                    end
                end else if (ImemReady) begin
                    pcf_d = w_pcf_plus4;
                    if (FlushD) begin
                        // Flushed response is dropped; the paired redirect refetches
                        w_src_valid = 1'b0;
                    end else if (StallD) begin
                        buf_instr_d = ImemRData;
                        buf_pc_d    = pcf_q;
                        state_d     = S_BUF;
                    end else begin
                        w_src_valid = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (PCSrcE) begin
                    pcf_d = w_target;
                end
                if (ImemReady) begin
                    state_d = S_REQ;
                end
            end
            S_BUF: begin
                if (PCSrcE) begin
                    pcf_d   = w_target;
                    state_d = S_REQ;
                end else if (!StallD) begin
                    w_src_valid = 1'b1;
                    w_src_instr = buf_instr_q;
                    w_src_pc    = buf_pc_q;
                    state_d     = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // IF/ID register: flush beats stall beats load beats bubble
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;

        if (FlushD) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (StallD) begin
            valid_d = valid_q;
        end else if (w_src_valid) begin
            instr_d = w_src_instr;
            pcd_d   = w_src_pc;
            pcp4_d  = w_src_pc_plus4;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    // State, fetch PC, skid buffer and IF/ID registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_REQ;
            pcf_q       <= C_RESET_PC_WORD;
            drop_addr_q <= C_RESET_PC_WORD;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= 32'd0;
            instr_q     <= NOP_INSTR;
            pcd_q       <= 32'd0;
            pcp4_q      <= 32'd0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            drop_addr_q <= drop_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instr_q     <= instr_d;
            pcd_q       <= pcd_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
        end
    end

endmodule
`default_nettype wire
